// File: rtl/jump_game_pkg.sv
// Shared types and constants for the jump game core.
package jump_game_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      OVER = 2'd2
   } game_state_t;

   typedef enum logic [1:0] {
      GROUND = 2'd0,
      RISE   = 2'd1,
      FALL   = 2'd2
   } jump_phase_t;

   // x^8 + x^6 + x^5 + x^4 + 1, taps as bit positions 7,5,4,3
   localparam logic [7:0]  LFSR_TAPS = 8'hB8;
   localparam int unsigned SCORE_W   = 16;

   function automatic logic lfsr_fb(input logic [7:0] v);
      return ^(v & LFSR_TAPS);
   endfunction

endpackage

// File: rtl/jump_game_tick.sv
// Free-running divider producing a one-cycle game tick every TICK_DIV clocks.
module jump_game_tick #(
   parameter int TICK_DIV = 250
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;

   assign tick = (cnt_q == LAST);

   // Count 0..TICK_DIV-1 and wrap; tick is high on the last count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/jump_game_core.sv
// Endless-runner game core: synchronised jump button, tick-paced jump and
// obstacle lane, collision detection and score.
// Optional double jump: define JUMP_GAME_DOUBLE_JUMP_EN.
module jump_game_core
   import jump_game_pkg::*;
#(
   parameter int         COLS      = 8,
   parameter int         ROWS      = 8,
   parameter int         JUMP_H    = 3,
   parameter int         TICK_DIV  = 250,
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    up,
   output logic [$clog2(ROWS)-1:0] height,
   output logic [COLS-1:0]         lane,
   output logic                    col,
   output logic [SCORE_W-1:0]      score,
   output logic [1:0]              state
);

   localparam int HW = $clog2(ROWS);
   localparam logic [HW-1:0] APEX_DEF = HW'(JUMP_H);

   logic tick;

   jump_game_tick #(
      .TICK_DIV(TICK_DIV)
   ) u_tick (
      .clk (clk),
      .rst (rst),
      .tick(tick)
   );

   logic up_s1_q, up_s2_q, up_s3_q;
   logic up_edge;

   game_state_t   state_q, state_d;
   jump_phase_t   phase_q, phase_d;
   logic [HW-1:0] height_q, height_d;
   logic [COLS-1:0] lane_q, lane_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [7:0]    lfsr_q, lfsr_d;
   logic          jump_req_q, jump_req_d;
   logic          can_req, take, new_bit;
   logic [HW-1:0] apex_cur;
`ifdef JUMP_GAME_DOUBLE_JUMP_EN
   localparam logic [HW-1:0] H_MAX = HW'(ROWS - 1);
   logic          credit_q, credit_d;
   logic [HW-1:0] apex_q, apex_d;
   logic [HW:0]   apex_sum;
`endif

   assign up_edge = up_s2_q & ~up_s3_q;
   // Obstacle only when the last two columns are empty.
   assign new_bit = (lane_q[1:0] == 2'b00) & lfsr_q[0] & lfsr_q[1];

   // Two-flop synchroniser plus one delay flop for edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         up_s1_q <= 1'b0;
         up_s2_q <= 1'b0;
         up_s3_q <= 1'b0;
      end else begin
         up_s1_q <= up;
         up_s2_q <= up_s1_q;
         up_s3_q <= up_s2_q;
      end
   end

   // Game and jump state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         phase_q    <= GROUND;
         height_q   <= '0;
         lane_q     <= '0;
         score_q    <= '0;
         lfsr_q     <= LFSR_SEED;
         jump_req_q <= 1'b0;
`ifdef JUMP_GAME_DOUBLE_JUMP_EN
         credit_q   <= 1'b1;
         apex_q     <= APEX_DEF;
`endif
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         height_q   <= height_d;
         lane_q     <= lane_d;
         score_q    <= score_d;
         lfsr_q     <= lfsr_d;
         jump_req_q <= jump_req_d;
`ifdef JUMP_GAME_DOUBLE_JUMP_EN
         credit_q   <= credit_d;
         apex_q     <= apex_d;
`endif
      end
   end

   // Next-state: game FSM, jump FSM, lane/LFSR shift, collision and score.
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      height_d   = height_q;
      lane_d     = lane_q;
      score_d    = score_q;
      lfsr_d     = lfsr_q;
      jump_req_d = jump_req_q;
      take       = 1'b0;
      apex_cur   = APEX_DEF;
`ifdef JUMP_GAME_DOUBLE_JUMP_EN
      credit_d   = credit_q;
      apex_d     = apex_q;
      apex_sum   = {1'b0, height_q} + (HW + 1)'(JUMP_H);
      can_req    = (phase_q == GROUND) | credit_q;
`else
      can_req    = (phase_q == GROUND);
`endif
      case (state_q)
         IDLE: begin
            if (up_edge) state_d = RUN;
         end
         RUN: begin
            if (up_edge && can_req) jump_req_d = 1'b1;
            if (tick) begin
               // A request arriving on the tick itself is taken immediately.
               take = jump_req_q | (up_edge & can_req);
               case (phase_q)
                  GROUND: begin
                     if (take) begin
                        jump_req_d = 1'b0;
                        height_d   = HW'(1);
                        phase_d    = (APEX_DEF <= HW'(1)) ? FALL : RISE;
`ifdef JUMP_GAME_DOUBLE_JUMP_EN
                        apex_d     = APEX_DEF;
`endif
                     end
                  end
                  default: begin
`ifdef JUMP_GAME_DOUBLE_JUMP_EN
                     if (take && credit_q) begin
                        jump_req_d = 1'b0;
                        credit_d   = 1'b0;
                        apex_d     = (apex_sum > {1'b0, H_MAX}) ? H_MAX : apex_sum[HW-1:0];
                        phase_d    = RISE;
                     end
                     apex_cur = apex_d;
`endif
                     if (phase_d == RISE) begin
                        if (height_q < apex_cur) height_d = height_q + HW'(1);
                        if (height_d >= apex_cur) phase_d = FALL;
                     end else begin
                        height_d = height_q - HW'(1);
                        if (height_d == '0) begin
                           phase_d = GROUND;
`ifdef JUMP_GAME_DOUBLE_JUMP_EN
                           credit_d = 1'b1;
`endif
                        end
                     end
                  end
               endcase
               lane_d = {lane_q[COLS-2:0], new_bit};
               lfsr_d = {lfsr_q[6:0], lfsr_fb(lfsr_q)};
               // Collision uses the post-update lane and height.
               if (lane_d[COLS-1] && (height_d == '0)) begin
                  state_d    = OVER;
                  jump_req_d = 1'b0;
               end else if (score_q != '1) begin
                  score_d = score_q + SCORE_W'(1);
               end
            end
         end
         OVER: begin
            if (up_edge) begin
               state_d    = IDLE;
               phase_d    = GROUND;
               height_d   = '0;
               lane_d     = '0;
               score_d    = '0;
               lfsr_d     = LFSR_SEED;
               jump_req_d = 1'b0;
`ifdef JUMP_GAME_DOUBLE_JUMP_EN
               credit_d   = 1'b1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign height = height_q;
   assign lane   = lane_q;
   assign score  = score_q;
   assign state  = state_q;
   assign col    = (state_q == OVER);

endmodule

// File: tb/tb_jump_game_core.sv
// Directed bench for jump_game_core with a tick-level reference model and a
// height scoreboard.
module tb_jump_game_core;
   import jump_game_pkg::*;

   localparam int TD = 4;

   logic        clk, rst, up;
   logic [2:0]  height;
   logic [7:0]  lane;
   logic        col;
   logic [15:0] score;
   logic [1:0]  state;

   int n_cmp = 0;
   int n_err = 0;
   int pe = 0;
   int edge_pe = -1;
   int exp_h[$];

   // Reference model state
   game_state_t m_st;
   int          m_h, m_ph, m_apex, m_score;
   bit          m_req, m_cred;
   logic [7:0]  m_lane, m_lfsr;

   jump_game_core #(
      .COLS(8), .ROWS(8), .JUMP_H(3), .TICK_DIV(TD), .LFSR_SEED(8'hA5)
   ) dut (
      .clk(clk), .rst(rst), .up(up), .height(height), .lane(lane),
      .col(col), .score(score), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic mdl_reset();
      m_st = IDLE; m_h = 0; m_ph = 0; m_apex = 3; m_score = 0;
      m_req = 0; m_cred = 1; m_lane = 8'h00; m_lfsr = 8'hA5;
   endtask

   // Behaviour of one clock edge as seen at game level.
   task automatic mdl_clock(input bit tk, input bit ed);
      bit nb;
      case (m_st)
         IDLE: if (ed) m_st = RUN;
         OVER: if (ed) begin
            m_st = IDLE; m_lane = 0; m_score = 0; m_h = 0; m_ph = 0;
            m_lfsr = 8'hA5; m_req = 0; m_cred = 1;
         end
         default: begin
`ifdef JUMP_GAME_DOUBLE_JUMP_EN
            if (ed && (m_ph == 0 || m_cred)) m_req = 1;
`else
            if (ed && m_ph == 0) m_req = 1;
`endif
            if (tk) begin
               if (m_ph == 0) begin
                  if (m_req) begin m_req = 0; m_h = 1; m_apex = 3; m_ph = 1; end
               end else begin
`ifdef JUMP_GAME_DOUBLE_JUMP_EN
                  if (m_req && m_cred) begin
                     m_req = 0; m_cred = 0; m_ph = 1;
                     m_apex = (m_h + 3 > 7) ? 7 : m_h + 3;
                  end
`endif
                  if (m_ph == 1) begin
                     if (m_h < m_apex) m_h++;
                     if (m_h >= m_apex) m_ph = 2;
                  end else begin
                     m_h--;
                     if (m_h == 0) begin m_ph = 0; m_cred = 1; end
                  end
               end
               nb = (m_lane[1:0] == 2'b00) && m_lfsr[0] && m_lfsr[1];
               m_lane = {m_lane[6:0], nb};
               m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
               if (m_lane[7] && m_h == 0) begin m_st = OVER; m_req = 0; end
               else if (m_score < 65535) m_score++;
            end
         end
      endcase
   endtask

   task automatic step();
      @(posedge clk);
      pe++;
      mdl_clock((pe % TD) == 0, pe == edge_pe);
      #1;
   endtask

   task automatic adv_tick();
      do step(); while ((pe % TD) != 0);
   endtask

   // Raise up for three edges; the synchronised edge lands on edge pe+3.
   task automatic press();
      up = 1'b1;
      edge_pe = pe + 3;
      repeat (3) step();
      up = 1'b0;
   endtask

   task automatic pop_h(output int e);
      e = exp_h.pop_front();
      check("jump_h", 32'(height), 32'(e));
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".state"},  32'(state),  32'(IDLE));
      check({tag, ".height"}, 32'(height), 0);
      check({tag, ".lane"},   32'(lane),   0);
      check({tag, ".col"},    32'(col),    0);
      check({tag, ".score"},  32'(score),  0);
   endtask

   task automatic check_tick_phase(input string tag);
      for (int i = 0; i < 8; i++) begin
         step();
         check(tag, 32'(dut.tick), 32'((pe % TD) == 3));
      end
   endtask

   task automatic release_rst();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      pe = 0;
      edge_pe = -1;
      mdl_reset();
   endtask

   initial begin
      int  e, prev, guard;
      bit  coinc_done, rst_done, p2, p3;
      logic [15:0] s_frz;
      logic [7:0]  l_frz;

      rst = 1'b0; up = 1'b0;
      mdl_reset();
      #2;
      check_zero("reset");
      release_rst();
      check_tick_phase("tick_first");
      check_zero("idle_hold");

      // Run 1: start, plain jump, jump on obstacle arrival, reset mid-rise.
      press();
      check("start_state", 32'(state), 32'(RUN));
      step();
      exp_h = {1, 2, 3, 2, 1, 0};
      press();
      if ((pe % TD) == 0) pop_h(e);
      guard = 0;
      while (exp_h.size() > 0 && guard < 20) begin
         adv_tick(); pop_h(e); guard++;
      end
      check("jump_score", 32'(score), 32'(m_score));

      coinc_done = 0; rst_done = 0;
      for (int i = 0; i < 40 && !rst_done; i++) begin
         if (m_st != RUN) break;
         if (!coinc_done && m_ph == 0 && !m_req && m_lane[6]) begin
            prev = m_score;
            step(); press();
            check("coinc_h",     32'(height),  1);
            check("coinc_lane7", 32'(lane[7]), 1);
            check("coinc_col",   32'(col),     0);
            check("coinc_state", 32'(state),   32'(RUN));
            check("coinc_score", 32'(score),   32'(prev + 1));
            coinc_done = 1;
         end else if (coinc_done && m_ph == 0 && !m_req && m_score == 19 && !m_lane[6]) begin
            step(); press();
            check("rise_h",     32'(height), 1);
            check("rise_score", 32'(score),  20);
            step();
            rst_done = 1;
         end else if (m_ph == 0 && !m_req && m_lane[6]) begin
            step(); press();
         end else begin
            adv_tick();
         end
      end
      check("coinc_seen", 32'(coinc_done), 1);
      check("rise20_seen", 32'(rst_done), 1);
      rst = 1'b0;
      #1;
      check_zero("midrun_rst");
      release_rst();
      check_tick_phase("tick_after_rst");
      check_zero("post_rst");

      // Run 2: repeated jump presses, then collision and return to idle.
      press();
      step();
`ifdef JUMP_GAME_DOUBLE_JUMP_EN
      exp_h = {1, 2, 3, 4, 5, 4, 3, 2, 1, 0};
`else
      exp_h = {1, 2, 3, 2, 1, 0};
`endif
      press();
      if ((pe % TD) == 0) pop_h(e);
      p2 = 0; p3 = 0; guard = 0;
      while (exp_h.size() > 0 && guard < 20) begin
         adv_tick(); pop_h(e); guard++;
         if (e == 2 && !p2) begin press(); p2 = 1; end
         else if (e == 3 && p2 && !p3) begin press(); p3 = 1; end
      end

      guard = 0;
      while (state !== OVER && guard < 60) begin
         adv_tick(); guard++;
      end
      check("over_state",  32'(state),  32'(OVER));
      check("over_model",  32'(m_st),   32'(OVER));
      check("over_col",    32'(col),    1);
      check("over_height", 32'(height), 0);
      check("over_score",  32'(score),  32'(m_score));
      check("over_lane",   32'(lane),   32'(m_lane));
      s_frz = score; l_frz = lane;
      repeat (8) step();
      check("frozen_score", 32'(score), 32'(s_frz));
      check("frozen_lane",  32'(lane),  32'(l_frz));
      check("frozen_col",   32'(col),   1);
      press();
      check_zero("over_to_idle");
      repeat (8) step();
      check_zero("idle_hold2");

      // Run 3: lane must replay from the reloaded seed.
      step();
      press();
      for (int i = 0; i < 10; i++) begin
         adv_tick();
         check("lane_seq", 32'(lane), 32'(m_lane));
      end
      check("seq_score", 32'(score), 32'(m_score));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
